stk_ctrl: RTL

STK_CTRL -- requirements
Module: stk_ctrl

---
 rtl/stk_pkg.sv | 23 ++
 rtl/stk_ram.sv | 33 +++
 rtl/stk_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stk_pkg.sv
// Shared constants, state encoding and pointer helpers for the 8-entry LIFO controller.
package stk_pkg;

    localparam int unsigned STK_DEPTH = 8;
    localparam int unsigned STK_PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        OUT
    } stk_state_e;

    // Pointer arithmetic relies on natural 3-bit wrap for the mod-8 behaviour.
    function automatic logic [STK_PTR_W-1:0] ptr_inc(input logic [STK_PTR_W-1:0] p);
        return p + 1'b1;
    endfunction

    function automatic logic [STK_PTR_W-1:0] ptr_dec(input logic [STK_PTR_W-1:0] p);
        return p - 1'b1;
    endfunction

endpackage

// File: rtl/stk_ram.sv
// 8 x WIDTH storage array: synchronous write, registered read, contents never reset.
module stk_ram
    import stk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [STK_PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [STK_PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [STK_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stk_ctrl.sv
// LIFO stack controller: IDLE/WR/RD/OUT FSM, stack counter and output register.
// Define STK_TRAP_EN to add the sticky ERR flag and its ERR_CLR input.
module stk_ctrl
    import stk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] DIN,
`ifdef STK_TRAP_EN
    input  logic             ERR_CLR,
`endif
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             BUSY,
    output logic [2:0]       SC,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ERR
);

    stk_state_e state_q, state_d;

    logic [STK_PTR_W-1:0] sc_q, sc_d;
    logic                 full_q, full_d;
    logic [WIDTH-1:0]     din_q, din_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    logic                 idle;
    logic                 empty;
    logic                 accept_push;
    logic                 accept_pop;
    logic                 ram_we;
    logic                 ram_re;
    logic [STK_PTR_W-1:0] ram_raddr;
    logic [WIDTH-1:0]     ram_rdata;

    assign idle  = (state_q == IDLE);
    assign empty = (sc_q == '0) && !full_q;

    // POP has priority; a PUSH seen together with POP is simply dropped.
    assign accept_pop  = idle && POP && !empty;
    assign accept_push = idle && PUSH && !POP && !full_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_pop) begin
                    state_d = RD;
                end else if (accept_push) begin
                    state_d = WR;
                end
            end
            WR:  state_d = IDLE;
            RD:  state_d = OUT;
            OUT: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY   = !idle;
        ram_we = (state_q == WR);
        ram_re = (state_q == RD);
    end

    assign ram_raddr = ptr_dec(sc_q);

    always_comb begin
        sc_d         = sc_q;
        full_d       = full_q;
        din_d        = din_q;
        dout_d       = dout_q;
        dout_valid_d = (state_q == OUT);
        if (accept_push) begin
            din_d = DIN;
        end
        if (state_q == WR) begin
            sc_d = ptr_inc(sc_q);
            if (sc_q == STK_PTR_W'(STK_DEPTH - 1)) begin
                full_d = 1'b1;
            end
        end
        if (state_q == RD) begin
            sc_d   = ptr_dec(sc_q);
            full_d = 1'b0;
        end
        if (state_q == OUT) begin
            dout_d = ram_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q         <= '0;
            full_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            sc_q         <= sc_d;
            full_q       <= full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Push data is only consumed in WR, so it needs no reset.
    always_ff @(posedge CLK) begin
        din_q <= din_d;
    end

    stk_ram #(
        .WIDTH(WIDTH)
    ) u_ram (
        .clk_i  (CLK),
        .we_i   (ram_we),
        .waddr_i(sc_q),
        .wdata_i(din_q),
        .re_i   (ram_re),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

`ifdef STK_TRAP_EN
    logic err_q, err_d;
    logic trap_ev;

    // A new event wins over a simultaneous clear so no error is lost.
    assign trap_ev = idle && ((POP && empty) || (PUSH && !POP && full_q));
    assign err_d   = trap_ev || (err_q && !ERR_CLR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign SC         = sc_q;
    assign EMPTY      = empty;
    assign FULL       = full_q;

endmodule
